// File: rtl/xadc_bram_reader.sv
// rtl/xadc_bram_reader.sv - XADC sample-table scanner: BRAM read initiator feeding an AXI-Stream master
// Optional feature macro: XADC_BRAM_READER_SEQ_EN adds m_axis_tuser carrying the scan sequence number.
module xadc_bram_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [31:0]           cfg_mask,
  input  logic [31:0]           cfg_period,
  output logic                  b_bram_clk,
  output logic                  b_bram_rst,
  output logic                  b_bram_en,
  output logic [ADDR_WIDTH-1:0] b_bram_addr,
  input  logic [DATA_WIDTH-1:0] b_bram_rdata,
  output logic [23:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
`ifdef XADC_BRAM_READER_SEQ_EN
  output logic [7:0]            m_axis_tuser,
`endif
  output logic [15:0]           sts_overrun,
  output logic                  sts_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} state_t;

  // tdata = {zero pad, address, sample}; a FIFO entry prepends the last flag
  localparam int PAD_W = 24 - ADDR_WIDTH - DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [ADDR_WIDTH-1:0] scan_addr_q, scan_addr_d;
  // read issue stage (drives the BRAM port)
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  en_last_q, en_last_d;
  // read return stage (b_bram_rdata valid this cycle)
  logic                  vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] vld_addr_q, vld_addr_d;
  logic                  vld_last_q, vld_last_d;
  // 2-entry output FIFO, ent0 is the head
  logic [24:0]           ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]            fcnt_q, fcnt_d;
  logic [15:0]           ovr_q, ovr_d;
`ifdef XADC_BRAM_READER_SEQ_EN
  logic [7:0]            seq_q, seq_d;
  logic [7:0]            tuser_q, tuser_d;
`endif

  logic                  tick;
  logic                  push;
  logic                  pop;
  logic                  can_issue;
  logic                  sel;
  logic [ADDR_WIDTH-1:0] hi_addr;
  logic [24:0]           din;

  assign b_bram_clk    = aclk;
  assign b_bram_rst    = ~aresetn;
  assign b_bram_en     = en_q;
  assign b_bram_addr   = addr_q;
  assign m_axis_tvalid = (fcnt_q != 2'd0);
  assign m_axis_tdata  = ent0_q[23:0];
  assign m_axis_tlast  = ent0_q[24];
  assign sts_overrun   = ovr_q;
  assign sts_busy      = (state_q != ST_IDLE);
`ifdef XADC_BRAM_READER_SEQ_EN
  assign m_axis_tuser  = tuser_q;
`endif

  // Next-state logic: period counter, scan FSM, read pipeline, output FIFO, status
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    last_addr_d = last_addr_q;
    scan_addr_d = scan_addr_q;
    en_d        = 1'b0;
    addr_d      = addr_q;
    en_last_d   = en_last_q;
    vld_d       = en_q;
    vld_addr_d  = addr_q;
    vld_last_d  = en_last_q;
    ent0_d      = ent0_q;
    ent1_d      = ent1_q;
    fcnt_d      = fcnt_q;
    ovr_d       = ovr_q;
`ifdef XADC_BRAM_READER_SEQ_EN
    seq_d       = seq_q;
    tuser_d     = tuser_q;
`endif
    tick        = 1'b0;
    hi_addr     = '0;

    // Period counter; a shrunken period that the counter already passed restarts it without a tick
    if (cfg_period == 32'd0) begin
      cnt_d = '0;
    end else if (cnt_q == cfg_period - 32'd1) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else if (cnt_q >= cfg_period) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    for (int i = 0; i < 32; i++) begin
      if (cfg_mask[i]) hi_addr = ADDR_WIDTH'(i);
    end

    pop  = m_axis_tvalid & m_axis_tready;
    push = vld_q;
    din  = {vld_last_q, {PAD_W{1'b0}}, vld_addr_q, b_bram_rdata};
    // Reads in flight plus FIFO occupancy may never exceed the 2 FIFO slots
    can_issue = ({1'b0, fcnt_q} + {2'b00, en_q} + {2'b00, vld_q}) < (3'd2 + {2'b00, pop});
    sel       = mask_q[scan_addr_q];

    if (tick && (state_q != ST_IDLE) && (ovr_q != 16'hFFFF)) begin
      ovr_d = ovr_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick && (cfg_mask != 32'd0)) begin
          state_d     = ST_SCAN;
          mask_d      = cfg_mask;
          last_addr_d = hi_addr;
          scan_addr_d = '0;
`ifdef XADC_BRAM_READER_SEQ_EN
          tuser_d     = seq_q;
          seq_d       = seq_q + 8'd1;
`endif
        end
      end
      ST_SCAN: begin
        // Unselected addresses are skipped at once; selected ones wait for FIFO room
        if (!sel || can_issue) begin
          if (sel) begin
            en_d      = 1'b1;
            addr_d    = scan_addr_q;
            en_last_d = (scan_addr_q == last_addr_q);
          end
          if (scan_addr_q == last_addr_q) begin
            state_d = ST_DRAIN;
          end else begin
            scan_addr_d = scan_addr_q + ADDR_ONE;
          end
        end
      end
      ST_DRAIN: begin
        if (!en_q && !vld_q && (fcnt_q == 2'd0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // FIFO: head stays put while stalled, so tdata/tlast hold under backpressure
    case ({push, pop})
      2'b10: begin
        if (fcnt_q == 2'd0) ent0_d = din;
        else                ent1_d = din;
        fcnt_d = fcnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        fcnt_d = fcnt_q - 2'd1;
      end
      2'b11: begin
        if (fcnt_q == 2'd1) begin
          ent0_d = din;
        end else begin
          ent0_d = ent1_q;
          ent1_d = din;
        end
      end
      default: ;
    endcase
  end

  // State registers; asynchronous reset aborts any scan in progress
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      last_addr_q <= '0;
      scan_addr_q <= '0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      en_last_q   <= 1'b0;
      vld_q       <= 1'b0;
      vld_addr_q  <= '0;
      vld_last_q  <= 1'b0;
      ent0_q      <= '0;
      ent1_q      <= '0;
      fcnt_q      <= '0;
      ovr_q       <= '0;
`ifdef XADC_BRAM_READER_SEQ_EN
      seq_q       <= '0;
      tuser_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      last_addr_q <= last_addr_d;
      scan_addr_q <= scan_addr_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      en_last_q   <= en_last_d;
      vld_q       <= vld_d;
      vld_addr_q  <= vld_addr_d;
      vld_last_q  <= vld_last_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      fcnt_q      <= fcnt_d;
      ovr_q       <= ovr_d;
`ifdef XADC_BRAM_READER_SEQ_EN
      seq_q       <= seq_d;
      tuser_q     <= tuser_d;
`endif
    end
  end

endmodule
